// File: rtl/tcp_packet_parser_if.sv
// Bus interfaces for the TCP receive path: IP packet input and byte-wide AXI-Stream.

interface ip_intf;
    localparam int unsigned DATA_W = 8;

    logic              ip_hdr_valid;
    logic              ip_hdr_ready;
    logic [15:0]       ip_length;
    logic [7:0]        ip_protocol;
    logic [31:0]       ip_source_ip;
    logic [31:0]       ip_dest_ip;
    logic [DATA_W-1:0] ip_payload_axis_tdata;
    logic              ip_payload_axis_tvalid;
    logic              ip_payload_axis_tready;
    logic              ip_payload_axis_tlast;
    logic              ip_payload_axis_tuser;

    modport MASTER (
        output ip_hdr_valid, ip_length, ip_protocol, ip_source_ip, ip_dest_ip,
               ip_payload_axis_tdata, ip_payload_axis_tvalid,
               ip_payload_axis_tlast, ip_payload_axis_tuser,
        input  ip_hdr_ready, ip_payload_axis_tready
    );

    modport SLAVE (
        input  ip_hdr_valid, ip_length, ip_protocol, ip_source_ip, ip_dest_ip,
               ip_payload_axis_tdata, ip_payload_axis_tvalid,
               ip_payload_axis_tlast, ip_payload_axis_tuser,
        output ip_hdr_ready, ip_payload_axis_tready
    );
endinterface

interface axis_intf;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;
    logic              tkeep;

    modport MASTER (output tdata, tvalid, tlast, tuser, tkeep, input tready);
    modport SLAVE  (input tdata, tvalid, tlast, tuser, tkeep, output tready);
endinterface

// File: rtl/tcp_packet_parser.sv
// TCP receive parser: captures the 20-byte header, skips options, streams the payload
// and reports header fields with a checksum/length verdict.

module tcp_packet_parser (
    input  logic        i_clk,
    input  logic        i_rst_n,
    ip_intf.SLAVE       s_ip,
    axis_intf.MASTER    m_axis_data,
    output logic        o_hdr_valid,
    input  logic        i_hdr_ready,
    output logic [15:0] o_src_port,
    output logic [15:0] o_dst_port,
    output logic [31:0] o_seq_number,
    output logic [31:0] o_ack_number,
    output logic [7:0]  o_flags,
    output logic [15:0] o_window_size,
    output logic [31:0] o_src_ip,
    output logic [31:0] o_dst_ip,
    output logic [15:0] o_payload_len,
    output logic        o_checksum_ok,
    output logic        o_packet_done,
    output logic        o_drop
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SUM_W = 32;
    localparam logic [7:0]       PROTO_TCP     = 8'd6;
    localparam logic [CNT_W-1:0] IP_HDR_LEN    = 16'd20;
    localparam logic [CNT_W-1:0] LAST_HDR_BYTE = 16'd19;
    localparam logic [3:0]       MIN_DATA_OFF  = 4'd5;

    typedef enum logic [2:0] {IDLE, HEADER, OPTIONS, DATA, DROP, STATUS} state_t;

    state_t           state_q, state_d;
    logic             hdr_ready_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [CNT_W-1:0] tcp_len_q;
    logic [CNT_W-1:0] payload_len_q;
    logic [SUM_W-1:0] csum_q;
    logic [3:0]       data_off_q;
    logic             err_q;
    logic             ok_q;
    logic             done_q;
    logic             drop_q;

    logic             hdr_hs;
    logic             rdy_c;
    logic             beat;
    logic             trunc_c;
    logic             drop_c;
    logic [7:0]       in_byte;
    logic [15:0]      byte_word;
    logic [CNT_W-1:0] hdr_end;
    logic [SUM_W-1:0] csum_next;
    logic [SUM_W-1:0] pseudo_sum;
    logic [16:0]      fold1;
    logic [15:0]      fold2;
    logic             csum_good;
    logic             len_bad;
    logic             verdict_ok;

    assign in_byte = s_ip.ip_payload_axis_tdata;
    assign hdr_hs  = s_ip.ip_hdr_valid & hdr_ready_q;
    assign rdy_c   = (state_q == HEADER) || (state_q == OPTIONS) || (state_q == DROP) ||
                     ((state_q == DATA) && m_axis_data.tready);
    assign beat    = s_ip.ip_payload_axis_tvalid & rdy_c;

    // Even TCP offsets carry the high byte; a trailing odd byte is implicitly zero-padded.
    assign byte_word  = byte_cnt_q[0] ? {8'h00, in_byte} : {in_byte, 8'h00};
    assign csum_next  = csum_q + SUM_W'(byte_word);
    assign fold1      = 17'(csum_next[15:0]) + 17'(csum_next[31:16]);
    assign fold2      = fold1[15:0] + 16'(fold1[16]);
    assign csum_good  = (fold2 == 16'hFFFF);
    assign len_bad    = (byte_cnt_q + 16'd1) != tcp_len_q;
    assign verdict_ok = csum_good & ~len_bad & ~err_q & ~s_ip.ip_payload_axis_tuser;
    assign hdr_end    = CNT_W'({data_off_q, 2'b00}) - 16'd1;

    assign pseudo_sum = SUM_W'(s_ip.ip_source_ip[31:16]) + SUM_W'(s_ip.ip_source_ip[15:0]) +
                        SUM_W'(s_ip.ip_dest_ip[31:16])   + SUM_W'(s_ip.ip_dest_ip[15:0])   +
                        SUM_W'(PROTO_TCP) + SUM_W'(s_ip.ip_length - IP_HDR_LEN);

    assign s_ip.ip_hdr_ready           = hdr_ready_q;
    assign s_ip.ip_payload_axis_tready = rdy_c;
    assign m_axis_data.tkeep           = 1'b1;
    assign o_hdr_valid                 = (state_q == STATUS);
    assign o_payload_len               = payload_len_q;
    assign o_checksum_ok               = ok_q;
    assign o_packet_done               = done_q;
    assign o_drop                      = drop_q;

    // Next-state and DATA pass-through
    always_comb begin
        state_d            = state_q;
        trunc_c            = 1'b0;
        drop_c             = 1'b0;
        m_axis_data.tvalid = 1'b0;
        m_axis_data.tdata  = in_byte;
        m_axis_data.tlast  = 1'b0;
        m_axis_data.tuser  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hdr_hs) begin
                    state_d = (s_ip.ip_protocol == PROTO_TCP) ? HEADER : DROP;
                end
            end
            HEADER: begin
                if (beat) begin
                    if (s_ip.ip_payload_axis_tlast) begin
                        if ((byte_cnt_q == LAST_HDR_BYTE) && (data_off_q >= MIN_DATA_OFF)) begin
                            state_d = STATUS;
                            trunc_c = (data_off_q != MIN_DATA_OFF);
                        end else begin
                            state_d = IDLE;
                            drop_c  = 1'b1;
                        end
                    end else if (byte_cnt_q == LAST_HDR_BYTE) begin
                        if (data_off_q < MIN_DATA_OFF) begin
                            state_d = DROP;
                        end else if (data_off_q > MIN_DATA_OFF) begin
                            state_d = OPTIONS;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            OPTIONS: begin
                if (beat) begin
                    if (s_ip.ip_payload_axis_tlast) begin
                        state_d = STATUS;
                        trunc_c = (byte_cnt_q != hdr_end);
                    end else if (byte_cnt_q == hdr_end) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                m_axis_data.tvalid = s_ip.ip_payload_axis_tvalid;
                m_axis_data.tlast  = s_ip.ip_payload_axis_tlast;
                m_axis_data.tuser  = s_ip.ip_payload_axis_tlast & ~verdict_ok;
                if (beat && s_ip.ip_payload_axis_tlast) begin
                    state_d = STATUS;
                end
            end
            DROP: begin
                if (beat && s_ip.ip_payload_axis_tlast) begin
                    state_d = IDLE;
                    drop_c  = 1'b1;
                end
            end
            STATUS: begin
                if (i_hdr_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            hdr_ready_q   <= 1'b0;
            byte_cnt_q    <= '0;
            tcp_len_q     <= '0;
            payload_len_q <= '0;
            csum_q        <= '0;
            data_off_q    <= '0;
            err_q         <= 1'b0;
            ok_q          <= 1'b0;
            done_q        <= 1'b0;
            drop_q        <= 1'b0;
            o_src_port    <= '0;
            o_dst_port    <= '0;
            o_seq_number  <= '0;
            o_ack_number  <= '0;
            o_flags       <= '0;
            o_window_size <= '0;
            o_src_ip      <= '0;
            o_dst_ip      <= '0;
        end else begin
            state_q     <= state_d;
            hdr_ready_q <= (state_d == IDLE);
            done_q      <= (state_q == STATUS) && i_hdr_ready;
            drop_q      <= drop_c;

            // New packet: pseudo-header seeds the checksum accumulator
            if (hdr_hs) begin
                o_src_ip      <= s_ip.ip_source_ip;
                o_dst_ip      <= s_ip.ip_dest_ip;
                tcp_len_q     <= s_ip.ip_length - IP_HDR_LEN;
                byte_cnt_q    <= '0;
                csum_q        <= pseudo_sum;
                err_q         <= 1'b0;
                payload_len_q <= '0;
                ok_q          <= 1'b0;
            end

            if (beat) begin
                byte_cnt_q <= byte_cnt_q + 16'd1;
                csum_q     <= csum_next;
                if (s_ip.ip_payload_axis_tuser) begin
                    err_q <= 1'b1;
                end
                if (state_q == DATA) begin
                    payload_len_q <= payload_len_q + 16'd1;
                end
                if (state_q == HEADER) begin
                    case (byte_cnt_q[4:0])
                        5'd0:  o_src_port[15:8]    <= in_byte;
                        5'd1:  o_src_port[7:0]     <= in_byte;
                        5'd2:  o_dst_port[15:8]    <= in_byte;
                        5'd3:  o_dst_port[7:0]     <= in_byte;
                        5'd4:  o_seq_number[31:24] <= in_byte;
                        5'd5:  o_seq_number[23:16] <= in_byte;
                        5'd6:  o_seq_number[15:8]  <= in_byte;
                        5'd7:  o_seq_number[7:0]   <= in_byte;
                        5'd8:  o_ack_number[31:24] <= in_byte;
                        5'd9:  o_ack_number[23:16] <= in_byte;
                        5'd10: o_ack_number[15:8]  <= in_byte;
                        5'd11: o_ack_number[7:0]   <= in_byte;
                        5'd12: data_off_q          <= in_byte[7:4];
                        5'd13: o_flags             <= in_byte;
                        5'd14: o_window_size[15:8] <= in_byte;
                        5'd15: o_window_size[7:0]  <= in_byte;
                        default: ;
                    endcase
                end
            end

            if ((state_d == STATUS) && (state_q != STATUS)) begin
                ok_q <= verdict_ok & ~trunc_c;
            end
        end
    end

endmodule

// File: tb/tb_tcp_packet_parser.sv
// Bench for tcp_packet_parser: vector table of packets, payload scoreboard, reset abort.

module tb_tcp_packet_parser;

    localparam logic [31:0] SRC_IP = 32'h0A00_0002;
    localparam logic [31:0] DST_IP = 32'h0A00_0001;
    localparam logic [39:0] HELLO  = 40'h68_65_6C_6C_6F;
    localparam int          NVEC   = 11;

    logic        clk;
    logic        rst_n;
    logic        hdr_ready;
    logic        hv;
    logic [15:0] sport_o, dport_o, win_o, plen_o;
    logic [31:0] seq_o, ack_o, sip_o, dip_o;
    logic [7:0]  flags_o;
    logic        ok_o, done_o, drop_o;

    ip_intf   ip_if();
    axis_intf ax_if();

    tcp_packet_parser dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .s_ip          (ip_if),
        .m_axis_data   (ax_if),
        .o_hdr_valid   (hv),
        .i_hdr_ready   (hdr_ready),
        .o_src_port    (sport_o),
        .o_dst_port    (dport_o),
        .o_seq_number  (seq_o),
        .o_ack_number  (ack_o),
        .o_flags       (flags_o),
        .o_window_size (win_o),
        .o_src_ip      (sip_o),
        .o_dst_ip      (dip_o),
        .o_payload_len (plen_o),
        .o_checksum_ok (ok_o),
        .o_packet_done (done_o),
        .o_drop        (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        logic [7:0]  proto;
        logic [3:0]  off;
        logic [7:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [15:0] win;
        int          pmode;
        int          plen;
        int          flip;
        int          ladj;
        int          tu;
        int          trunc;
        bit          bp;
        bit          edrop;
        bit          eok;
        int          eplen;
    } vec_t;

    beat_t      sb_q[$];
    logic [7:0] pkt[$];
    logic [15:0] ip_len;
    vec_t       vecs[NVEC];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_done = 0;
    int         n_drop = 0;
    int         n_hv = 0;
    bit         bp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [7:0] proto, logic [3:0] off, logic [7:0] flags,
                                logic [31:0] seq, int pmode, int plen, int flip, int ladj,
                                int tu, int trunc, bit bp, bit edrop, bit eok, int eplen);
        vec_t v;
        v.proto = proto;   v.off = off;     v.flags = flags;
        v.seq   = seq;     v.ack = seq ^ 32'h0F0F_0F0F;
        v.sport = 16'd1234; v.dport = 16'd80; v.win = 16'hFAF0 ^ 16'(plen);
        v.pmode = pmode;   v.plen = plen;   v.flip = flip;  v.ladj = ladj;
        v.tu    = tu;      v.trunc = trunc; v.bp = bp;
        v.edrop = edrop;   v.eok = eok;     v.eplen = eplen;
        return v;
    endfunction

    function automatic logic [7:0] pbyte(int mode, int i);
        logic [39:0] h;
        h = HELLO;
        if (mode == 0) return h[8*(4-i) +: 8];
        if (mode == 1) return 8'hAA + 8'(i * 17);
        return 8'(i * 7 + 3);
    endfunction

    // Builds the IP payload for a vector; TCP checksum computed over the finished segment.
    task automatic build(input vec_t v, output int ps);
        logic [31:0] sum;
        logic [15:0] w, ck;
        int          hb;
        pkt.delete();
        ps = 0;
        if (v.proto != 8'd6) begin
            for (int i = 0; i < v.plen; i++) pkt.push_back(pbyte(v.pmode, i));
            ip_len = 16'(20 + v.plen);
        end else begin
            hb = int'(v.off) * 4;
            pkt.push_back(v.sport[15:8]); pkt.push_back(v.sport[7:0]);
            pkt.push_back(v.dport[15:8]); pkt.push_back(v.dport[7:0]);
            for (int i = 3; i >= 0; i--) pkt.push_back(v.seq[8*i +: 8]);
            for (int i = 3; i >= 0; i--) pkt.push_back(v.ack[8*i +: 8]);
            pkt.push_back({v.off, 4'h0}); pkt.push_back(v.flags);
            pkt.push_back(v.win[15:8]);   pkt.push_back(v.win[7:0]);
            for (int i = 0; i < 4; i++) pkt.push_back(8'h00);
            for (int i = 20; i < hb; i++) pkt.push_back(8'h01);
            ps = pkt.size();
            for (int i = 0; i < v.plen; i++) pkt.push_back(pbyte(v.pmode, i));
            ip_len = 16'(20 + pkt.size() + v.ladj);
            sum = 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) +
                  32'(DST_IP[15:0]) + 32'd6 + 32'(ip_len - 16'd20);
            for (int i = 0; i < pkt.size(); i += 2) begin
                w = {pkt[i], (i + 1 < pkt.size()) ? pkt[i+1] : 8'h00};
                sum = sum + 32'(w);
            end
            sum = 32'(sum[15:0]) + 32'(sum[31:16]);
            sum = 32'(sum[15:0]) + 32'(sum[31:16]);
            ck = ~sum[15:0];
            pkt[16] = ck[15:8];
            pkt[17] = ck[7:0];
            if (v.flip >= 0) pkt[ps + v.flip] = pkt[ps + v.flip] ^ 8'h01;
            if (v.trunc >= 0) while (pkt.size() > v.trunc + 1) void'(pkt.pop_back());
        end
    endtask

    task automatic send_hdr(input logic [7:0] proto);
        int   n;
        logic r;
        ip_if.ip_hdr_valid = 1'b1;
        ip_if.ip_length    = ip_len;
        ip_if.ip_protocol  = proto;
        ip_if.ip_source_ip = SRC_IP;
        ip_if.ip_dest_ip   = DST_IP;
        n = 0;
        do begin
            @(negedge clk);
            r = ip_if.ip_hdr_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 200);
        #1;
        ip_if.ip_hdr_valid = 1'b0;
        if (!r) chk("ip header handshake", 64'(r), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic user);
        int   n;
        logic r;
        ip_if.ip_payload_axis_tdata  = b;
        ip_if.ip_payload_axis_tlast  = last;
        ip_if.ip_payload_axis_tuser  = user;
        ip_if.ip_payload_axis_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            r = ip_if.ip_payload_axis_tready;
            @(posedge clk);
            n++;
        end while (!r && n < 200);
        #1;
        if (!r) chk("payload byte accepted", 64'(r), 64'd1);
    endtask

    task automatic idle_payload();
        ip_if.ip_payload_axis_tvalid = 1'b0;
        ip_if.ip_payload_axis_tlast  = 1'b0;
        ip_if.ip_payload_axis_tuser  = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t  v;
        beat_t e;
        int    ps, d0, p0, h0, n;
        logic  got, last;
        v = vecs[k];
        build(v, ps);
        d0 = n_done; p0 = n_drop; h0 = n_hv;
        bp_on = v.bp;
        send_hdr(v.proto);
        for (int i = 0; i < pkt.size(); i++) begin
            last = (i == pkt.size() - 1);
            if (!v.edrop && v.proto == 8'd6 && i >= ps) begin
                e.data = pkt[i];
                e.last = last;
                e.user = last & ~v.eok;
                sb_q.push_back(e);
            end
            send_byte(pkt[i], last, 1'(i == v.tu));
        end
        idle_payload();
        if (v.edrop) begin
            repeat (6) @(posedge clk);
            #1;
            chk($sformatf("v%0d drop pulses", k), 64'(n_drop - p0), 64'd1);
            chk($sformatf("v%0d hdr_valid cycles", k), 64'(n_hv - h0), 64'd0);
            chk($sformatf("v%0d done pulses", k), 64'(n_done - d0), 64'd0);
            chk($sformatf("v%0d beats left", k), 64'(sb_q.size()), 64'd0);
        end else begin
            n = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                got = hv;
                n++;
            end
            chk($sformatf("v%0d hdr_valid", k), 64'(got), 64'd1);
            chk($sformatf("v%0d ports", k), 64'({sport_o, dport_o}), 64'({v.sport, v.dport}));
            chk($sformatf("v%0d seq", k), 64'(seq_o), 64'(v.seq));
            chk($sformatf("v%0d ack", k), 64'(ack_o), 64'(v.ack));
            chk($sformatf("v%0d flags/window", k), 64'({flags_o, win_o}), 64'({v.flags, v.win}));
            chk($sformatf("v%0d ips", k), {sip_o, dip_o}, {SRC_IP, DST_IP});
            chk($sformatf("v%0d payload_len", k), 64'(plen_o), 64'(v.eplen));
            chk($sformatf("v%0d checksum_ok", k), 64'(ok_o), 64'(v.eok));
            if (v.bp) begin
                repeat (10) begin
                    @(negedge clk);
                    chk($sformatf("v%0d stall {hdr_valid,ip_hdr_ready}", k),
                        64'({hv, ip_if.ip_hdr_ready}), 64'(2'b10));
                end
            end
            hdr_ready = 1'b1;
            @(posedge clk);
            #1;
            hdr_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d done pulses", k), 64'(n_done - d0), 64'd1);
            chk($sformatf("v%0d drop pulses", k), 64'(n_drop - p0), 64'd0);
            chk($sformatf("v%0d beats left", k), 64'(sb_q.size()), 64'd0);
        end
        bp_on = 1'b0;
    endtask

    // Output monitor: pulse counters and payload scoreboard
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done_o) n_done++;
                if (drop_o) n_drop++;
                if (hv)     n_hv++;
                if (ax_if.tvalid && ax_if.tready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL m_axis beat: got unexpected 0x%0h expected none", ax_if.tdata);
                    end else begin
                        e = sb_q.pop_front();
                        chk("m_axis beat {data,last,user,keep}",
                            64'({ax_if.tdata, ax_if.tlast, ax_if.tuser, ax_if.tkeep}),
                            64'({e.data, e.last, e.user, 1'b1}));
                    end
                end
            end
        end
    end

    initial begin
        ax_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ax_if.tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  v;
        beat_t e;
        int    ps;
        rst_n     = 1'b0;
        hdr_ready = 1'b0;
        ip_if.ip_hdr_valid = 1'b0;
        ip_if.ip_length    = '0;
        ip_if.ip_protocol  = '0;
        ip_if.ip_source_ip = '0;
        ip_if.ip_dest_ip   = '0;
        ip_if.ip_payload_axis_tdata = '0;
        idle_payload();

        //            proto  off  flags  seq            pm plen flip ladj tu trunc bp drop ok eplen
        vecs[0]  = mk(8'd6,  4'd5, 8'h02, 32'h1234_5678, 0, 0,  -1,  0,  -1, -1,  0, 0,  1, 0);
        vecs[1]  = mk(8'd6,  4'd5, 8'h18, 32'hA000_0001, 0, 5,  -1,  0,  -1, -1,  0, 0,  1, 5);
        vecs[2]  = mk(8'd6,  4'd5, 8'h18, 32'hA000_0001, 0, 5,   2,  0,  -1, -1,  0, 0,  0, 5);
        vecs[3]  = mk(8'd6,  4'd6, 8'h18, 32'h0BAD_BEEF, 1, 3,  -1,  0,  -1, -1,  0, 0,  1, 3);
        vecs[4]  = mk(8'd17, 4'd5, 8'h00, 32'h0,         2, 30, -1,  0,  -1, -1,  0, 1,  0, 0);
        vecs[5]  = mk(8'd6,  4'd4, 8'h10, 32'h0000_0100, 2, 10, -1,  0,  -1, -1,  0, 1,  0, 0);
        vecs[6]  = mk(8'd6,  4'd5, 8'h18, 32'h5555_0000, 2, 4,  -1,  1,  -1, -1,  0, 0,  0, 4);
        vecs[7]  = mk(8'd6,  4'd5, 8'h18, 32'h7777_7777, 2, 6,  -1,  0,   5, -1,  0, 0,  0, 6);
        vecs[8]  = mk(8'd6,  4'd5, 8'h02, 32'h0000_0008, 0, 0,  -1,  0,  -1, 10,  0, 1,  0, 0);
        vecs[9]  = mk(8'd6,  4'd7, 8'h18, 32'hCAFE_F00D, 2, 5,  -1,  0,  -1, 23,  0, 0,  0, 0);
        vecs[10] = mk(8'd6,  4'd5, 8'h18, 32'hDEAD_0010, 2, 20, -1,  0,  -1, -1,  1, 0,  1, 20);

        repeat (2) @(negedge clk);
        chk("reset {hdr_valid,hdr_ready,tready,m_valid,m_last,m_user,done,drop,ok}",
            64'({hv, ip_if.ip_hdr_ready, ip_if.ip_payload_axis_tready, ax_if.tvalid,
                 ax_if.tlast, ax_if.tuser, done_o, drop_o, ok_o}), 64'd0);
        chk("reset fields", 64'({sport_o, seq_o, plen_o}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < NVEC; k++) run_vec(k);

        // Reset in the middle of a DATA burst
        v = vecs[1];
        build(v, ps);
        send_hdr(8'd6);
        for (int i = 0; i < ps + 2; i++) begin
            if (i >= ps) begin
                e.data = pkt[i];
                e.last = 1'b0;
                e.user = 1'b0;
                sb_q.push_back(e);
            end
            send_byte(pkt[i], 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        idle_payload();
        #1;
        chk("mid-packet reset {hdr_valid,hdr_ready,tready,m_valid,m_last,m_user,done,drop,ok}",
            64'({hv, ip_if.ip_hdr_ready, ip_if.ip_payload_axis_tready, ax_if.tvalid,
                 ax_if.tlast, ax_if.tuser, done_o, drop_o, ok_o}), 64'd0);
        chk("mid-packet reset fields", 64'({sport_o, seq_o, plen_o}), 64'd0);
        chk("mid-packet reset src_ip", 64'(sip_o), 64'd0);
        chk("beats forwarded before reset", 64'(sb_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
